radix4_ifft16: RTL

Sixteen-point radix-4 inverse FFT on complex Q16.16 data. It is the receive-side counterpart of `radix4_fft`: it takes a spectrum frame on the same 512-bit packed buses and returns time-domain samples scaled by 1/16. A single shared butterfly engine runs iteratively: 2 stages × 4 butterflies. Valid/ready handshakes sit on both sides.

---
 rtl/fft16_pkg.sv | 27 ++
 rtl/radix4_ibfly.sv | 57 +++++
 rtl/radix4_ifft16.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/fft16_pkg.sv
// Shared definitions for the 16-point radix-4 FFT/IFFT blocks: Q16.16 width,
// point count, complex sample type, controller states, the twiddle constants
// and the digit-reversal index map used when a frame is loaded.
package fft16_pkg;

  localparam int QW   = 32;  // Q16.16 word width
  localparam int NPTS = 16;  // transform length

  // Twiddle magnitudes in Q16.16.
  localparam logic signed [QW-1:0] ONE       = 32'sd65536;
  localparam logic signed [QW-1:0] COS_PI8   = 32'sd60547;
  localparam logic signed [QW-1:0] SIN_PI8   = 32'sd25080;
  localparam logic signed [QW-1:0] SQRT_HALF = 32'sd46341;

  typedef struct packed {
    logic signed [QW-1:0] re;
    logic signed [QW-1:0] im;
  } cplx_t;

  typedef enum logic [1:0] {IDLE, ST1, ST2, DONE} state_t;

  // Bin 4a+b lands in slot 4b+a: swap the two base-4 digits.
  function automatic logic [3:0] digit_rev(input logic [3:0] idx);
    return {idx[1:0], idx[3:2]};
  endfunction

endpackage

// File: rtl/radix4_ibfly.sv
// Combinational 4-point inverse butterfly with divide-by-4 scaling.
// Rounding is selected by RADIX4_IFFT_ROUND_EN (defined: +2 before the
// shift, round-half-up; undefined: plain arithmetic truncation).
module radix4_ibfly
  import fft16_pkg::*;
(
  input  cplx_t x0,
  input  cplx_t x1,
  input  cplx_t x2,
  input  cplx_t x3,
  output cplx_t y0,
  output cplx_t y1,
  output cplx_t y2,
  output cplx_t y3
);

  typedef logic signed [QW+1:0] wide_t;

  function automatic wide_t widen(input logic signed [QW-1:0] v);
    return wide_t'(v);
  endfunction

  function automatic logic signed [QW-1:0] scale4(input wide_t s);
    wide_t t;
`ifdef RADIX4_IFFT_ROUND_EN
    t = s + wide_t'(2);
`else
    t = s;
`endif
    return QW'(t >>> 2);
  endfunction

  wide_t ar, ai, br, bi, cr, ci, dr, di;

  assign ar = widen(x0.re);
  assign ai = widen(x0.im);
  assign br = widen(x1.re);
  assign bi = widen(x1.im);
  assign cr = widen(x2.re);
  assign ci = widen(x2.im);
  assign dr = widen(x3.re);
  assign di = widen(x3.im);

  // Inverse kernel: y1 = a + jb - c - jd, y3 = a - jb - c + jd, each scaled by 1/4.
  // NOTE: combinational blocks use blocking '=' so each output settles in one evaluation.
  always_comb begin
    y0.re = scale4(ar + br + cr + dr);
    y0.im = scale4(ai + bi + ci + di);
    y1.re = scale4(ar - bi - cr + di);
    y1.im = scale4(ai + br - ci - dr);
    y2.re = scale4(ar - br + cr - dr);
    y2.im = scale4(ai - bi + ci - di);
    y3.re = scale4(ar + bi - cr - di);
    y3.im = scale4(ai - br - ci + dr);
  end

endmodule

// File: rtl/radix4_ifft16.sv
// 16-point radix-4 inverse FFT, Q16.16, output scaled by 1/16.
// One shared butterfly runs 2 stages x 4 butterflies, one per clock, on an
// in-place frame buffer. Valid/ready on both sides; frames do not overlap.
// RADIX4_IFFT_ROUND_EN selects round-half-up in the butterfly and twiddle
// multiply; when undefined both truncate. Latency is identical either way.
module radix4_ifft16
  import fft16_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [NPTS*QW-1:0]   pt_r_in,
  input  logic [NPTS*QW-1:0]   pt_i_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [NPTS*QW-1:0]   pt_r_out,
  output logic [NPTS*QW-1:0]   pt_i_out
);

  state_t      state;
  logic [1:0]  cnt;
  cplx_t       slot_q [NPTS];
  logic [3:0]  idx    [4];
  cplx_t       bf_in  [4];
  cplx_t       bf_out [4];
  logic        accept;

  assign accept = (state == IDLE) && in_valid && in_ready;

  // Conjugate twiddle e^{+j*2*pi*k/16}; stage 2 only needs k = g*m <= 9.
  function automatic cplx_t twiddle(input logic [3:0] k);
    cplx_t w;
    case (k)
      4'd1:    begin w.re =  COS_PI8;   w.im =  SIN_PI8;   end
      4'd2:    begin w.re =  SQRT_HALF; w.im =  SQRT_HALF; end
      4'd3:    begin w.re =  SIN_PI8;   w.im =  COS_PI8;   end
      4'd4:    begin w.re =  '0;        w.im =  ONE;       end
      4'd5:    begin w.re = -SIN_PI8;   w.im =  COS_PI8;   end
      4'd6:    begin w.re = -SQRT_HALF; w.im =  SQRT_HALF; end
      4'd7:    begin w.re = -COS_PI8;   w.im =  SIN_PI8;   end
      4'd8:    begin w.re = -ONE;       w.im =  '0;        end
      4'd9:    begin w.re = -COS_PI8;   w.im = -SIN_PI8;   end
      default: begin w.re =  ONE;       w.im =  '0;        end
    endcase
    return w;
  endfunction

  // Full-precision complex product, then keep bits [47:16] of each part.
  function automatic cplx_t cmul(input cplx_t x, input cplx_t w);
    logic signed [63:0] xr, xi, wr, wi, p_re, p_im;
    cplx_t r;
    xr   = 64'(x.re);
    xi   = 64'(x.im);
    wr   = 64'(w.re);
    wi   = 64'(w.im);
    p_re = xr * wr - xi * wi;
    p_im = xr * wi + xi * wr;
`ifdef RADIX4_IFFT_ROUND_EN
    p_re = p_re + 64'sd32768;
    p_im = p_im + 64'sd32768;
`endif
    r.re = QW'(p_re >>> 16);
    r.im = QW'(p_im >>> 16);
    return r;
  endfunction

  // Select the butterfly's slots (consecutive in ST1, stride 4 in ST2) and twiddle in ST2.
  always_comb begin
    for (int m = 0; m < 4; m++) begin
      if (state == ST2) idx[m] = {2'(m), cnt};
      else              idx[m] = {cnt, 2'(m)};
      if (state == ST2) bf_in[m] = cmul(slot_q[idx[m]], twiddle(4'(m) * {2'b00, cnt}));
      else              bf_in[m] = slot_q[idx[m]];
    end
  end

  radix4_ibfly u_bfly (
    .x0 (bf_in[0]),
    .x1 (bf_in[1]),
    .x2 (bf_in[2]),
    .x3 (bf_in[3]),
    .y0 (bf_out[0]),
    .y1 (bf_out[1]),
    .y2 (bf_out[2]),
    .y3 (bf_out[3])
  );

  // Frame controller: accept, 4 butterflies per stage, then hold the result until taken.
  // NOTE: sequential state uses non-blocking '<=' so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 2'd0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state    <= ST1;
            cnt      <= 2'd0;
            in_ready <= 1'b0;
          end
        end
        ST1: begin
          cnt <= cnt + 2'd1;
          if (cnt == 2'd3) state <= ST2;
        end
        ST2: begin
          cnt <= cnt + 2'd1;
          if (cnt == 2'd3) begin
            state     <= DONE;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Frame buffer: digit-reversed load on accept, in-place write-back while computing.
  // NOTE: the buffer is deliberately not reset; it is only visible through out_valid, which reset clears.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int k = 0; k < NPTS; k++)
        slot_q[digit_rev(4'(k))] <= {pt_r_in[QW*k +: QW], pt_i_in[QW*k +: QW]};
    end else if (state == ST1 || state == ST2) begin
      for (int m = 0; m < 4; m++)
        slot_q[idx[m]] <= bf_out[m];
    end
  end

  // Present the buffer only while a finished frame is on offer; zero otherwise.
  // NOTE: defaults first so no path leaves the outputs unassigned (no latch).
  always_comb begin
    pt_r_out = '0;
    pt_i_out = '0;
    if (out_valid) begin
      for (int n = 0; n < NPTS; n++) begin
        pt_r_out[QW*n +: QW] = slot_q[n].re;
        pt_i_out[QW*n +: QW] = slot_q[n].im;
      end
    end
  end

endmodule
